// File: rtl/mmu_pkg.sv
// Shared encodings for the MMU controller: request op codes, completion codes
// and FSM state encoding.
package mmu_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FLUSH = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ES_OK     = 2'b00,
    ES_PFAULT = 2'b01,
    ES_PROT   = 2'b10,
    ES_BADOP  = 2'b11
  } esito_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_TFETCH = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/mmu_tlb.sv
// Fully associative TLB with parallel tag match, round-robin refill and flush-all.
// With MMU_PROT_EN defined each entry also stores a write-permit bit.
module mmu_tlb #(
  parameter int VPN_W   = 4,
  parameter int FRAME_W = 6,
  parameter int NENT    = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic [VPN_W-1:0]   vpn,
  output logic               hit,
  output logic [FRAME_W-1:0] frame,
`ifdef MMU_PROT_EN
  output logic               perm,
  input  logic               fill_perm,
`endif
  input  logic               fill,
  input  logic [FRAME_W-1:0] fill_frame
);

  localparam int IDX_W = $clog2(NENT);

  logic [NENT-1:0]    valid;
  logic [VPN_W-1:0]   tag [NENT];
  logic [FRAME_W-1:0] frm [NENT];
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   fill_idx;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NENT; i++) begin
      if (valid[i] && tag[i] == vpn) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign frame = frm[hit_idx];

  // A refill always targets the vpn being looked up, so a hit here means an
  // equal-vpn entry that is rewritten in place instead of duplicated.
  assign fill_idx = hit ? hit_idx : ptr;

  // NOTE: state uses non-blocking assignments; only valid bits and the pointer
  // need reset, since an invalid slot's tag and frame are never observed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      ptr   <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (fill) begin
      valid[fill_idx] <= 1'b1;
      if (!hit) ptr <= ptr + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      tag[fill_idx] <= vpn;
      frm[fill_idx] <= fill_frame;
    end
  end

`ifdef MMU_PROT_EN
  logic prm [NENT];

  always_ff @(posedge clock) begin
    if (fill) prm[fill_idx] <= fill_perm;
  end

  assign perm = prm[hit_idx];
`endif

endmodule

// File: rtl/mmu_ctrl_p.sv
// MMU controller: translates logical requests through a TLB, refilling from an
// in-memory relocation table. Define MMU_PROT_EN to enforce the write-permit bit.
module mmu_ctrl_p
  import mmu_pkg::*;
#(
  parameter int                OFF_W    = 4,
  parameter int                LOG_W    = 8,
  parameter int                PHYS_W   = 10,
  parameter int                DATA_W   = 16,
  parameter int                NENT     = 4,
  parameter logic [PHYS_W-1:0] TAB_BASE = 10'h300
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rdyin,
  input  logic [1:0]        op,
  input  logic [LOG_W-1:0]  ind_log,
  input  logic [DATA_W-1:0] datain,
  output logic              ackout,
  output logic [1:0]        esito,
  output logic [DATA_W-1:0] dataout,
  output logic              rdyoutm,
  output logic              opoutm,
  output logic [PHYS_W-1:0] indoutm,
  output logic [DATA_W-1:0] dataoutm,
  input  logic              ackinm,
  input  logic [DATA_W-1:0] datainm
);

  localparam int VPN_W   = LOG_W - OFF_W;
  localparam int FRAME_W = PHYS_W - OFF_W;

  state_e             state, state_d;
  logic [1:0]         op_q;
  logic [LOG_W-1:0]   log_q;
  logic [DATA_W-1:0]  data_q;
  logic [FRAME_W-1:0] frame_q;
  logic [1:0]         esito_d;
  logic               tlb_hit, tlb_fill, tlb_flush, wr_denied;
  logic [FRAME_W-1:0] tlb_frame;
  logic [VPN_W-1:0]   vpn;
  logic [OFF_W-1:0]   offset;

  assign vpn    = log_q[LOG_W-1:OFF_W];
  assign offset = log_q[OFF_W-1:0];

`ifdef MMU_PROT_EN
  logic tlb_perm, perm_now;
  // During a refill the permit comes straight from the fetched table word.
  assign perm_now  = (state == S_TFETCH) ? datainm[DATA_W-2] : tlb_perm;
  assign wr_denied = (op_q == OP_WRITE) && !perm_now;
`else
  assign wr_denied = 1'b0;
`endif

  mmu_tlb #(.VPN_W(VPN_W), .FRAME_W(FRAME_W), .NENT(NENT)) u_tlb (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (tlb_flush),
    .vpn        (vpn),
    .hit        (tlb_hit),
    .frame      (tlb_frame),
`ifdef MMU_PROT_EN
    .perm       (tlb_perm),
    .fill_perm  (datainm[DATA_W-2]),
`endif
    .fill       (tlb_fill),
    .fill_frame (datainm[FRAME_W-1:0])
  );

  always_comb begin
    state_d   = state;
    esito_d   = esito;
    tlb_fill  = 1'b0;
    tlb_flush = 1'b0;
    unique case (state)
      S_IDLE: if (rdyin) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (op_q == OP_FLUSH) begin
          tlb_flush = 1'b1;
          esito_d   = ES_OK;
          state_d   = S_DONE;
        end else if (op_q == OP_RSVD) begin
          esito_d = ES_BADOP;
          state_d = S_DONE;
        end else if (!tlb_hit) begin
          state_d = S_TFETCH;
        end else if (wr_denied) begin
          esito_d = ES_PROT;
          state_d = S_DONE;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_TFETCH: begin
        if (ackinm) begin
          if (!datainm[DATA_W-1]) begin
            esito_d = ES_PFAULT;
            state_d = S_DONE;
          end else begin
            tlb_fill = 1'b1;
            if (wr_denied) begin
              esito_d = ES_PROT;
              state_d = S_DONE;
            end else begin
              state_d = S_ACCESS;
            end
          end
        end
      end
      S_ACCESS: begin
        if (ackinm) begin
          esito_d = ES_OK;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs decode straight from state so reset clears them at once.
  always_comb begin
    rdyoutm  = 1'b0;
    opoutm   = 1'b0;
    indoutm  = '0;
    dataoutm = '0;
    if (state == S_TFETCH) begin
      rdyoutm = 1'b1;
      indoutm = TAB_BASE + PHYS_W'(vpn);
    end else if (state == S_ACCESS) begin
      rdyoutm  = 1'b1;
      opoutm   = op_q[0];
      indoutm  = {frame_q, offset};
      dataoutm = data_q;
    end
  end

  assign ackout = (state == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      log_q   <= '0;
      data_q  <= '0;
      frame_q <= '0;
      esito   <= '0;
      dataout <= '0;
    end else begin
      state <= state_d;
      esito <= esito_d;
      if (state == S_IDLE && rdyin) begin
        op_q   <= op;
        log_q  <= ind_log;
        data_q <= datain;
      end
      if (state == S_LOOKUP && tlb_hit) frame_q <= tlb_frame;
      if (state == S_TFETCH && ackinm) frame_q <= datainm[FRAME_W-1:0];
      if (state == S_ACCESS && ackinm && op_q == OP_READ) dataout <= datainm;
    end
  end

endmodule

// File: tb/tb_mmu_ctrl_p.sv
// Self-checking bench for mmu_ctrl_p: directed scenarios plus randomized traffic
// against a FIFO-TLB transaction model and a behavioural memory.
module tb_mmu_ctrl_p;

  localparam int         OFF_W    = 4;
  localparam int         LOG_W    = 8;
  localparam int         PHYS_W   = 10;
  localparam int         DATA_W   = 16;
  localparam int         NENT     = 4;
  localparam logic [9:0] TAB_BASE = 10'h300;
`ifdef MMU_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clock = 1'b0, reset_n = 1'b0, rdyin = 1'b0;
  logic [1:0]  op = '0;
  logic [7:0]  ind_log = '0;
  logic [15:0] datain = '0;
  logic        ackout, rdyoutm, opoutm;
  logic [1:0]  esito;
  logic [15:0] dataout, dataoutm;
  logic [9:0]  indoutm;
  logic        ackinm = 1'b0;
  logic [15:0] datainm = '0;

  always #5 clock = ~clock;

  mmu_ctrl_p #(
    .OFF_W(OFF_W), .LOG_W(LOG_W), .PHYS_W(PHYS_W), .DATA_W(DATA_W),
    .NENT(NENT), .TAB_BASE(TAB_BASE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rdyin(rdyin), .op(op), .ind_log(ind_log),
    .datain(datain), .ackout(ackout), .esito(esito), .dataout(dataout),
    .rdyoutm(rdyoutm), .opoutm(opoutm), .indoutm(indoutm), .dataoutm(dataoutm),
    .ackinm(ackinm), .datainm(datainm)
  );

  typedef struct { logic op; logic [9:0] addr; logic [15:0] data; logic chk; } req_t;
  typedef struct { logic [1:0] esito; logic [15:0] data; logic chk; } rsp_t;
  typedef struct { logic [3:0] vpn; logic [5:0] frame; logic perm; } ent_t;

  logic [15:0] mem [1024];
  req_t        exp_req [$];
  rsp_t        exp_rsp [$];
  ent_t        tlb_m [$];
  logic [9:0]  req_log [$];
  int          fixed_lat = -1;
  bit          noise_en = 1'b0;
  int          n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: FIFO of translations, table words read from mem.
  task automatic predict(input logic [1:0] o, input logic [7:0] la, input logic [15:0] wd);
    logic [3:0]  vpn = la[7:4];
    logic [15:0] w = 16'h0;
    logic [9:0]  a;
    int          idx = -1;
    ent_t        e = '{4'h0, 6'h0, 1'b0};
    rsp_t        r = '{2'b00, 16'h0, 1'b0};
    if (o == 2'b10) tlb_m.delete();
    else if (o == 2'b11) r.esito = 2'b11;
    else begin
      foreach (tlb_m[i]) if (tlb_m[i].vpn == vpn) idx = i;
      if (idx >= 0) e = tlb_m[idx];
      else begin
        exp_req.push_back('{1'b0, TAB_BASE + 10'(vpn), 16'h0, 1'b0});
        w = mem[TAB_BASE + 10'(vpn)];
        if (w[15]) begin
          e = '{vpn, w[5:0], w[14]};
          if (tlb_m.size() == NENT) void'(tlb_m.pop_front());
          tlb_m.push_back(e);
        end
      end
      if (idx < 0 && !w[15]) r.esito = 2'b01;
      else if (o == 2'b01 && PROT && !e.perm) r.esito = 2'b10;
      else begin
        a = {e.frame, la[3:0]};
        exp_req.push_back('{o[0], a, wd, 1'b1});
        if (o == 2'b00) begin
          r.chk  = 1'b1;
          r.data = mem[a];
        end
      end
    end
    exp_rsp.push_back(r);
  endtask

  // Memory responder and output checker.
  bit   pending = 1'b0;
  int   lat_left = 0;
  req_t q;
  rsp_t r;
  always @(negedge clock) begin
    ackinm  = 1'b0;
    datainm = 16'($urandom);
    if (!rdyoutm) begin
      pending = 1'b0;
      if ($urandom_range(0, 5) == 0) ackinm = 1'b1;
    end else begin
      if (!pending) begin
        pending  = 1'b1;
        lat_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      if (lat_left == 0) begin
        ackinm  = 1'b1;
        pending = 1'b0;
        req_log.push_back(indoutm);
        if (exp_req.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL req_unexpected: got op %0b addr %0h, required no request", opoutm, indoutm);
        end else begin
          q = exp_req.pop_front();
          check("req_op", 32'(opoutm), 32'(q.op));
          check("req_addr", 32'(indoutm), 32'(q.addr));
          if (q.chk) check("req_wdata", 32'(dataoutm), 32'(q.data));
        end
        if (opoutm) mem[indoutm] = dataoutm;
        else datainm = mem[indoutm];
      end else lat_left--;
    end
    if (ackout) begin
      if (exp_rsp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL ack_unexpected: got ackout esito %0h, required no completion", esito);
      end else begin
        r = exp_rsp.pop_front();
        check("esito", 32'(esito), 32'(r.esito));
        if (r.chk) check("dataout", 32'(dataout), 32'(r.data));
      end
    end
  end

  task automatic run(input logic [1:0] o, input logic [7:0] la, input logic [15:0] wd,
                     output logic [1:0] es, output logic [15:0] dout,
                     output int lat, output int nreq);
    int cnt;
    @(negedge clock);
    predict(o, la, wd);
    req_log.delete();
    rdyin   = 1'b1;
    op      = o;
    ind_log = la;
    datain  = wd;
    @(negedge clock);
    cnt = 1;
    while (!ackout && cnt < 100) begin
      rdyin   = noise_en && ($urandom_range(0, 1) == 1);
      op      = 2'($urandom);
      ind_log = 8'($urandom);
      datain  = 16'($urandom);
      @(negedge clock);
      cnt++;
    end
    rdyin = 1'b0;
    if (!ackout) check("ack_timeout", 32'(ackout), 32'd1);
    check("req_drain", 32'(exp_req.size()), 32'd0);
    es   = esito;
    dout = dataout;
    lat  = cnt;
    nreq = req_log.size();
  endtask

  logic [1:0]  es;
  logic [15:0] dout;
  int          lat, nreq;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clock);
    check("rst_ackout", 32'(ackout), 32'd0);
    check("rst_rdyoutm", 32'(rdyoutm), 32'd0);
    check("rst_opoutm", 32'(opoutm), 32'd0);
    check("rst_esito", 32'(esito), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    check("rst_indoutm", 32'(indoutm), 32'd0);
    check("rst_dataoutm", 32'(dataoutm), 32'd0);
    reset_n = 1'b1;

    // Cold read, then the same read as a TLB hit.
    mem[10'h303] = 16'h8005;
    mem[10'h055] = 16'hBEEF;
    run(2'b00, 8'h35, 16'h0, es, dout, lat, nreq);
    check("cold_esito", 32'(es), 32'h0);
    check("cold_data", 32'(dout), 32'hBEEF);
    check("cold_nreq", 32'(nreq), 32'd2);
    check("cold_tab_addr", 32'(req_log[0]), 32'h303);
    check("cold_acc_addr", 32'(req_log[1]), 32'h055);
    fixed_lat = 0;
    run(2'b00, 8'h35, 16'h0, es, dout, lat, nreq);
    check("hit_nreq", 32'(nreq), 32'd1);
    check("hit_latency", 32'(lat), 32'd3);
    check("hit_data", 32'(dout), 32'hBEEF);
    fixed_lat = -1;

    // Page fault leaves the TLB alone.
    mem[10'h307] = 16'h0000;
    run(2'b00, 8'h70, 16'h0, es, dout, lat, nreq);
    check("fault_esito", 32'(es), 32'h1);
    check("fault_nreq", 32'(nreq), 32'd1);
    run(2'b00, 8'h35, 16'h0, es, dout, lat, nreq);
    check("fault_tlb_kept", 32'(nreq), 32'd1);

    // Flush, five misses, then vpn 0 must have been evicted.
    run(2'b10, 8'h00, 16'h0, es, dout, lat, nreq);
    check("flush_esito", 32'(es), 32'h0);
    for (int v = 0; v < 5; v++) mem[TAB_BASE + 10'(v)] = 16'h8000 | 16'(v + 8);
    for (int v = 0; v < 5; v++) run(2'b00, 8'(v * 16 + 3), 16'h0, es, dout, lat, nreq);
    run(2'b00, 8'h01, 16'h0, es, dout, lat, nreq);
    check("evict_refetch", 32'(nreq), 32'd2);
    run(2'b00, 8'h41, 16'h0, es, dout, lat, nreq);
    check("evict_keep4", 32'(nreq), 32'd1);

    // Write to a page whose permit bit is clear.
    mem[10'h309] = 16'h8005;
    run(2'b01, 8'h9A, 16'h1234, es, dout, lat, nreq);
`ifdef MMU_PROT_EN
    check("prot_esito", 32'(es), 32'h2);
    check("prot_nreq", 32'(nreq), 32'd1);
`else
    check("wr_esito", 32'(es), 32'h0);
    check("wr_nreq", 32'(nreq), 32'd2);
    check("wr_addr", 32'(req_log[1]), 32'h05A);
    check("wr_mem", 32'(mem[10'h05A]), 32'h1234);
`endif
    run(2'b11, 8'h12, 16'h0, es, dout, lat, nreq);
    check("badop_esito", 32'(es), 32'h3);

    // Reset in the middle of a hit access on vpn 4 (frame 12).
    fixed_lat = 8;
    @(negedge clock);
    rdyin   = 1'b1;
    op      = 2'b00;
    ind_log = 8'h4C;
    @(negedge clock);
    rdyin = 1'b0;
    for (int i = 0; i < 20 && !rdyoutm; i++) @(negedge clock);
    check("mid_rdyoutm", 32'(rdyoutm), 32'd1);
    check("mid_addr", 32'(indoutm), 32'h0CC);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rdyoutm", 32'(rdyoutm), 32'd0);
    check("mid_rst_indoutm", 32'(indoutm), 32'd0);
    check("mid_rst_ackout", 32'(ackout), 32'd0);
    exp_req.delete();
    exp_rsp.delete();
    tlb_m.delete();
    @(negedge clock);
    reset_n   = 1'b1;
    fixed_lat = -1;
    run(2'b00, 8'h4C, 16'h0, es, dout, lat, nreq);
    check("post_rst_miss", 32'(nreq), 32'd2);

    // Randomized traffic with noise on rdyin while busy.
    for (int v = 0; v < 16; v++)
      mem[TAB_BASE + 10'(v)] = {($urandom_range(0, 4) != 0), 1'($urandom), 8'h00, 6'($urandom)};
    noise_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      int          sel = int'($urandom_range(0, 19));
      logic [1:0]  o = (sel < 9) ? 2'b00 : (sel < 17) ? 2'b01 : (sel < 18) ? 2'b10 : 2'b11;
      run(o, 8'($urandom), 16'($urandom), es, dout, lat, nreq);
    end
    noise_en = 1'b0;
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
